// File: rtl/sort_sequencer.sv
// sort_sequencer: in-place bubble sort of the first len words of an external
// single-port synchronous RAM, with start/busy/done handshake and early exit.
module sort_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  descend,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [15:0]           swap_count
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] CAP = LW'(2 ** ADDR_WIDTH);
  typedef enum logic [2:0] {IDLE, RD0, RD1, CMP, WR0, WR1, DONE} state_t;
  state_t state, state_n;
  logic [LW-1:0] len_r, len_c, last;
  logic [ADDR_WIDTH-1:0] j, pass;
  logic [DATA_WIDTH-1:0] a_reg, b_reg;
  logic desc_r, swapped, swap, more, fin, adv;
  always_comb begin
    len_c = len > CAP ? CAP : len;
    last = len_r - LW'(2) - {1'b0, pass};
    more = {1'b0, j} < last;
    fin = !swapped || last == '0;
    swap = desc_r ? a_reg < ram_rdata : a_reg > ram_rdata;
    adv = (state == CMP && !swap) || state == WR1;
    state_n = state;
    unique case (state)
      IDLE: state_n = start ? (len_c < LW'(2) ? DONE : RD0) : IDLE;
      RD0:  state_n = RD1;
      RD1:  state_n = CMP;
      CMP:  state_n = swap ? WR0 : (more || !fin ? RD0 : DONE);
      WR0:  state_n = WR1;
      WR1:  state_n = more || !fin ? RD0 : DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy = !(state == IDLE || state == DONE);
    done = state == DONE;
    ram_we = state == WR0 || state == WR1;
    ram_addr = (state == RD0 || state == WR0) ? j :
               (state == RD1 || state == WR1) ? j + 1'b1 : '0;
    ram_wdata = state == WR0 ? b_reg : state == WR1 ? a_reg : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_r <= '0;
      desc_r <= 1'b0;
      j <= '0;
      pass <= '0;
      swapped <= 1'b0;
      swap_count <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      if (state == IDLE && start) begin
        len_r <= len_c;
        desc_r <= descend;
        j <= '0;
        pass <= '0;
        swapped <= 1'b0;
        swap_count <= '0;
      end
      if (state == RD1) a_reg <= ram_rdata;
      if (state == CMP && swap) begin
        b_reg <= ram_rdata;
        swapped <= 1'b1;
        swap_count <= &swap_count ? swap_count : swap_count + 16'd1;
      end
      // end of a pass that still needs another one restarts the index
      if (adv && more) j <= j + 1'b1;
      else if (adv && !fin) begin
        j <= '0;
        pass <= pass + 1'b1;
        swapped <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sort_sequencer.sv
// tb_sort_sequencer: scoreboard bench with a behavioural RAM and a reference sort.
module tb_sort_sequencer;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, descend = 1'b0, load = 1'b0;
  logic [4:0] len = '0;
  logic busy, done, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic [15:0] swap_count;
  logic [7:0] mem[16];
  logic [7:0] init_v[16];
  int n_chk = 0, n_pass = 0;
  int exp_q[$];
  always #5 clk = ~clk;
  sort_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .descend(descend),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .swap_count(swap_count)
  );
  always @(posedge clk)
    if (load) for (int k = 0; k < 16; k++) mem[k] <= init_v[k];
    else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic load_mem;
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask
  task automatic run_sort(input string tag, input int n, input bit d, input int exp_cyc,
                          input int poke, input bit no_we, input bit no_addr);
    int nc, inv, cyc, dones, we_seen, addr_seen, busy_at_done, t, k, e;
    int v[16];
    bit got;
    nc = n > 16 ? 16 : n;
    for (int i = 0; i < 16; i++) v[i] = mem[i];
    inv = 0;
    for (int i = 0; i < nc; i++)
      for (int m = i + 1; m < nc; m++)
        if (d ? v[i] < v[m] : v[i] > v[m]) inv++;
    for (int i = 1; i < nc; i++) begin
      t = v[i];
      k = i;
      while (k > 0 && (d ? v[k-1] < t : v[k-1] > t)) begin
        v[k] = v[k-1];
        k--;
      end
      v[k] = t;
    end
    exp_q.push_back(inv > 65535 ? 65535 : inv);
    exp_q.push_back(exp_cyc);
    for (int i = 0; i < 16; i++) exp_q.push_back(v[i]);
    @(negedge clk);
    start = 1'b1;
    len = n[4:0];
    descend = d;
    cyc = 0; dones = 0; we_seen = 0; addr_seen = 0; busy_at_done = 0; got = 1'b0;
    while (!got && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == poke) begin
        start = 1'b1;
        len = 5'd2;
      end else start = 1'b0;
      if (ram_we) we_seen++;
      if (ram_addr != 0) addr_seen++;
      if (done) begin
        got = 1'b1;
        dones++;
        busy_at_done = busy;
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, got, 1);
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    e = exp_q.pop_front();
    check({tag, " swap_count"}, swap_count, e);
    e = exp_q.pop_front();
    if (e >= 0) check({tag, " done_cycle"}, cyc, e);
    check({tag, " busy_at_done"}, busy_at_done, 0);
    check({tag, " done_pulses"}, dones, 1);
    if (no_we) check({tag, " we_cycles"}, we_seen, 0);
    if (no_addr) check({tag, " addr_nonzero"}, addr_seen, 0);
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s mem[%0d]", tag, i), mem[i], e);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst ram_we", ram_we, 0);
    check("rst ram_addr", ram_addr, 0);
    check("rst ram_wdata", ram_wdata, 0);
    check("rst swap_count", swap_count, 0);
    reset = 1'b1;
    init_v = '{3, 1, 2, 0, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 11, 12};
    load_mem;
    run_sort("asc4", 4, 0, 29, -1, 0, 0);
    for (int i = 0; i < 16; i++) init_v[i] = 8'(i);
    load_mem;
    run_sort("sorted", 16, 0, 46, -1, 1, 0);
    for (int i = 0; i < 16; i++) init_v[i] = 8'(15 - i);
    load_mem;
    run_sort("rev_asc", 16, 0, 601, -1, 0, 0);
    load_mem;
    run_sort("rev_desc", 16, 1, 46, -1, 1, 0);
    init_v = '{5, 5, 2, 5, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    load_mem;
    run_sort("dup", 4, 0, 23, -1, 0, 0);
    for (int i = 0; i < 16; i++) init_v[i] = 8'($urandom_range(0, 255));
    load_mem;
    run_sort("len0", 0, 0, 1, -1, 1, 1);
    run_sort("len1", 1, 0, 1, -1, 1, 1);
    run_sort("clamp", 31, 1, -1, -1, 0, 0);
    for (int i = 0; i < 16; i++) init_v[i] = 8'(15 - i);
    load_mem;
    run_sort("busy_start", 16, 0, 601, 30, 0, 0);
    load_mem;
    @(negedge clk);
    start = 1'b1;
    len = 5'd16;
    descend = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst ram_we", ram_we, 0);
    check("midrst swap_count", swap_count, 0);
    @(negedge clk);
    reset = 1'b1;
    run_sort("after_rst", 16, 0, -1, -1, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sort_sequencer.md
# sort_sequencer

Bubble-sort controller that sequences an external single-port synchronous RAM through read / compare / conditional-swap-write phases, sorting the first `len` words in place. It contains the pass and index counters, the two operand registers and the compare-and-swap decision. It exposes a start/busy/done handshake to the host and terminates early when a pass completes with no swaps. It sits between the host and the sort RAM, and replaces ad-hoc counter/controller glue.

## Interface
- DATA_WIDTH, 8, element width in bits
- ADDR_WIDTH, 4, RAM address width; capacity is 2^ADDR_WIDTH words
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a sort; sampled only in IDLE
- len  in  ADDR_WIDTH+1  element count, sampled with start; values above 2^ADDR_WIDTH clamp to 2^ADDR_WIDTH
- descend  in  1  0 = ascending, 1 = descending; sampled with start
- busy  out  1  high while sorting
- done  out  1  one-cycle completion pulse
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_WIDTH  RAM write data; meaningful only when ram_we=1
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after its address is presented
- swap_count  out  16  number of swaps in the current/last sort; saturates at 0xFFFF

## Operation
- States: IDLE, RD0, RD1, CMP, WR0, WR1, DONE.
- IDLE:
  - On start: latch len (clamped) and descend; clear j, pass, swapped flag and swap_count.
  - If len<2 go to DONE, otherwise go to RD0.
- RD0: ram_addr=j → RD1.
- RD1: ram_addr=j+1; capture ram_rdata into a_reg → CMP.
- CMP: b=ram_rdata; swap = descend ? (a_reg<b) : (a_reg>b). Equal values never swap.
  - If swap: b_reg<=b, set swapped, increment swap_count (saturating) → WR0.
  - Else apply the advance rule.
- WR0: ram_addr=j, ram_we=1, ram_wdata=b_reg → WR1.
- WR1: ram_addr=j+1, ram_we=1, ram_wdata=a_reg; then apply the advance rule.
- Advance rule, with last = len-2-pass:
  - If j<last: j++ → RD0.
  - Else (end of pass): if swapped=0 or last=0 → DONE; otherwise pass++, j=0, swapped=0 → RD0.
- DONE: done=1 for this single cycle → IDLE.
- busy=1 in RD0..WR1, and 0 in IDLE and DONE.
- start is ignored outside IDLE; a start held high into DONE is not accepted until IDLE.
- swap_count holds its value after DONE until the next accepted start.
- ram_addr=0 and ram_we=0 in IDLE and DONE.
- Compares are unsigned.

## Timing
- Reset values: busy=0, done=0, ram_we=0, ram_addr=0, ram_wdata=0, swap_count=0, state IDLE.
- Reset asserted mid-sort: immediate return to IDLE with reset values. RAM contents are left partially sorted; no completion is signalled.
- Cycle 0 = the IDLE cycle in which start is sampled high. The first RD0 occurs at cycle 1.
- Per compare: 3 cycles without a swap, 5 cycles with a swap.
- done asserts the cycle after the final CMP or WR1.
- len<2: done at cycle 1; no RAM access.
- RAM read latency is exactly 1 cycle. A write in WR1 followed by a read of the same address in the next RD0/RD1 must return the new data; the RAM must be write-first or the addresses separated.
- Worst case for len=N: N(N-1)/2 compares, all swapping, i.e. 5·N(N-1)/2 cycles + 1.

## Test plan
- Ascending, len=4, RAM [3,1,2,0] → RAM [0,1,2,3]; swap_count=5; exactly one done pulse; busy low on the done cycle.
- Already sorted, len=16, RAM 0..15 → one pass of 15 compares, never ram_we; done at cycle 46; swap_count=0.
- Reversed data, len=16, RAM 15..0:
  - descend=0 → RAM 0..15, swap_count=120.
  - Reload and run with descend=1 → unchanged, swap_count=0.
- Duplicates, len=4, RAM [5,5,2,5], ascending → RAM [2,5,5,5]; swap_count=2; done after pass 3.
- len=0, and separately len=1 → done at cycle 1; ram_we never high; ram_addr stays 0.
- Assert start while busy → ignored; swap_count is not cleared.
- Assert reset low mid-pass → busy=0, done=0, ram_we=0 immediately; a subsequent start sorts correctly.
